// File: rtl/serial_subtractor_16bit.sv
// Bit-serial subtractor: diff = a - b - borrow_in, one bit per clock, LSB first.
// A start/busy/done handshake frames each operation; results live in a held output register.
module serial_subtractor_16bit #(
    parameter int NUM_BITS = 16
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic                borrow_in,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] diff,
    output logic                underflow
);

    localparam int CNT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NUM_BITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_BITS-1:0] shift_a_q, shift_a_d;
    logic [NUM_BITS-1:0] shift_b_q, shift_b_d;
    logic [NUM_BITS-1:0] shift_d_q, shift_d_d;
    logic                br_q, br_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [NUM_BITS-1:0] diff_q, diff_d;
    logic                underflow_q, underflow_d;

    logic                bit_res;
    logic                br_next;
    logic [NUM_BITS-1:0] shifted_res;

    function automatic logic sub_bit(input logic x, input logic y, input logic bi);
        return x ^ y ^ bi;
    endfunction

    function automatic logic borrow_bit(input logic x, input logic y, input logic bi);
        return (~x & y) | (~(x ^ y) & bi);
    endfunction

    assign bit_res     = sub_bit(shift_a_q[0], shift_b_q[0], br_q);
    assign br_next     = borrow_bit(shift_a_q[0], shift_b_q[0], br_q);
    assign shifted_res = {bit_res, shift_d_q[NUM_BITS-1:1]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_a_d   = shift_a_q;
        shift_b_d   = shift_b_q;
        shift_d_d   = shift_d_q;
        br_d        = br_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        diff_d      = diff_q;
        underflow_d = underflow_q;

        case (state_q)
            IDLE, DONE: begin
                // DONE behaves like IDLE for acceptance, giving back-to-back operation
                busy_d  = 1'b0;
                state_d = IDLE;
                if (start) begin
                    shift_a_d = a;
                    shift_b_d = b;
                    br_d      = borrow_in;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                shift_a_d = shift_a_q >> 1;
                shift_b_d = shift_b_q >> 1;
                shift_d_d = shifted_res;
                br_d      = br_next;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    diff_d      = shifted_res;
                    underflow_d = br_next;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    state_d     = DONE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_a_q   <= '0;
            shift_b_q   <= '0;
            shift_d_q   <= '0;
            br_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            diff_q      <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_a_q   <= shift_a_d;
            shift_b_q   <= shift_b_d;
            shift_d_q   <= shift_d_d;
            br_q        <= br_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            diff_q      <= diff_d;
            underflow_q <= underflow_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign diff      = diff_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_serial_subtractor_16bit.sv
// Bench for serial_subtractor_16bit: per-cycle comparison against an arithmetic
// model, plus directed operations with hand-computed results.
module tb_serial_subtractor_16bit;

    logic        clk;
    logic        n_rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        borrow_in;
    logic        busy;
    logic        done;
    logic [15:0] diff;
    logic        underflow;

    int n_vec;
    int n_err;
    int done_seen;
    int done_expected;
    bit cmp_en;

    // Model: an accepted operation finishes 16 edges later with the plain
    // 17-bit difference; nothing else is accepted while one is pending.
    logic        m_busy;
    logic        m_done;
    logic [15:0] m_diff;
    logic        m_uf;
    int          m_left;
    logic [16:0] m_pend;

    serial_subtractor_16bit #(.NUM_BITS(16)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .borrow_in (borrow_in),
        .busy      (busy),
        .done      (done),
        .diff      (diff),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_diff <= '0;
            m_uf   <= 1'b0;
            m_left <= 0;
            m_pend <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_diff <= m_pend[15:0];
                    m_uf   <= m_pend[16];
                end
            end else if (start) begin
                m_pend <= {1'b0, a} - {1'b0, b} - {16'd0, borrow_in};
                m_left <= 16;
                m_busy <= 1'b1;
            end
        end
    end

    task automatic check(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            if (done === 1'b1) done_seen++;
            check(busy === m_busy, "cyc_busy", {31'd0, busy}, {31'd0, m_busy});
            check(done === m_done, "cyc_done", {31'd0, done}, {31'd0, m_done});
            check(diff === m_diff, "cyc_diff", {16'd0, diff}, {16'd0, m_diff});
            check(underflow === m_uf, "cyc_underflow", {31'd0, underflow}, {31'd0, m_uf});
        end
    end

    // Caller sits at a falling edge; start is seen by the next rising edge.
    task automatic issue(input logic [15:0] ta, input logic [15:0] tb_v, input logic tbin);
        start     = 1'b1;
        a         = ta;
        b         = tb_v;
        borrow_in = tbin;
        @(negedge clk);
        start     = 1'b0;
        a         = 16'($urandom);
        b         = 16'($urandom);
        borrow_in = 1'($urandom);
    endtask

    task automatic await_result(input logic [15:0] ed, input logic eu, input int lat0, input string nm);
        int lat;
        lat = lat0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        done_expected++;
        check(done === 1'b1, {nm, "_done_seen"}, {31'd0, done}, 32'd1);
        check(lat == 17, {nm, "_latency"}, lat, 32'd17);
        check(diff === ed, {nm, "_diff"}, {16'd0, diff}, {16'd0, ed});
        check(underflow === eu, {nm, "_underflow"}, {31'd0, underflow}, {31'd0, eu});
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic        rbin;
        logic [16:0] rexp;
        int          dones_before;

        n_vec = 0; n_err = 0; done_seen = 0; done_expected = 0; cmp_en = 0;
        start = 0; a = 0; b = 0; borrow_in = 0;
        n_rst = 1'b1;
        #1 n_rst = 1'b0;
        cmp_en = 1;
        repeat (3) @(negedge clk);
        check(busy === 1'b0, "reset_busy", {31'd0, busy}, 32'd0);
        check(done === 1'b0, "reset_done", {31'd0, done}, 32'd0);
        check(diff === 16'h0000, "reset_diff", {16'd0, diff}, 32'd0);
        check(underflow === 1'b0, "reset_underflow", {31'd0, underflow}, 32'd0);
        n_rst = 1'b1;
        @(negedge clk);

        // 1: all zero
        issue(16'h0000, 16'h0000, 1'b0);
        check(busy === 1'b1, "t1_busy_after_accept", {31'd0, busy}, 32'd1);
        await_result(16'h0000, 1'b0, 1, "t1");

        // 2: wrap to 0xFFFF with underflow, then hold
        @(negedge clk);
        issue(16'h0001, 16'h0002, 1'b0);
        await_result(16'hFFFF, 1'b1, 1, "t2");
        repeat (5) @(negedge clk);
        check(diff === 16'hFFFF, "t2_hold_diff", {16'd0, diff}, 32'hFFFF);
        check(underflow === 1'b1, "t2_hold_underflow", {31'd0, underflow}, 32'd1);

        // 3: borrow_in, then back-to-back start during DONE
        issue(16'hF918, 16'h0001, 1'b1);
        await_result(16'hF916, 1'b0, 1, "t3a");
        issue(16'h0221, 16'hFCAC, 1'b0);
        await_result(16'h0575, 1'b1, 1, "t3b");

        // 4: start while busy is ignored
        @(negedge clk);
        dones_before = done_seen;
        issue(16'h2345, 16'h1111, 1'b0);
        repeat (4) @(negedge clk);
        start = 1'b1; a = 16'hFFFF; b = 16'h0000; borrow_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        await_result(16'h1234, 1'b0, 6, "t4");
        repeat (4) @(negedge clk);
        check(done_seen - dones_before == 1, "t4_single_done", done_seen - dones_before, 32'd1);

        // 5: asynchronous reset mid-operation
        issue(16'hFDBA, 16'h0123, 1'b0);
        repeat (7) @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        check(busy === 1'b0, "t5_rst_busy", {31'd0, busy}, 32'd0);
        check(done === 1'b0, "t5_rst_done", {31'd0, done}, 32'd0);
        check(diff === 16'h0000, "t5_rst_diff", {16'd0, diff}, 32'd0);
        check(underflow === 1'b0, "t5_rst_underflow", {31'd0, underflow}, 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        dones_before = done_seen;
        repeat (25) @(negedge clk);
        check(done_seen == dones_before, "t5_no_done_after_abort", done_seen - dones_before, 32'd0);
        issue(16'h0010, 16'h0010, 1'b1);
        await_result(16'hFFFF, 1'b1, 1, "t5");

        // 6: random operands against plain arithmetic, some back-to-back
        for (int i = 0; i < 100; i++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rbin = 1'($urandom);
            rexp = {1'b0, ra} - {1'b0, rb} - {16'd0, rbin};
            if ($urandom_range(0, 1) == 0) @(negedge clk);
            issue(ra, rb, rbin);
            await_result(rexp[15:0], rexp[16], 1, "rand");
        end

        repeat (3) @(negedge clk);
        check(done_seen == done_expected, "done_count", done_seen, done_expected);
        cmp_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_subtractor_16bit.md
Name: serial_subtractor_16bit

Overview:
Bit-serial, multi-cycle subtractor that computes diff = a - b - borrow_in, LSB first, one bit per clock. It is the inverse-operation counterpart of the combinational adder_16bit datapath and serves as the area-minimal subtract path beside it. A start/busy/done handshake frames each operation. Results are held in a dedicated output register so they stay stable between operations.

Parameters:
NUM_BITS, 16, operand and result width; the bit counter width is clog2(NUM_BITS).

Ports:
clk  input  1  system clock, rising-edge active
n_rst  input  1  asynchronous active-low reset
start  input  1  request a new operation; sampled at the rising edge of clk
a  input  NUM_BITS  minuend; sampled only on an accepted start
b  input  NUM_BITS  subtrahend; sampled only on an accepted start
borrow_in  input  1  initial borrow; sampled only on an accepted start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse marking that a new result is valid
diff  output  NUM_BITS  registered difference
underflow  output  1  registered final borrow-out; 1 when a < b + borrow_in (unsigned)

Behaviour:
- Reset: n_rst low forces the following, asynchronously:
  - state to IDLE
  - counter, shift registers and borrow flop to 0
  - busy, done, diff and underflow to 0
- States: IDLE, BUSY, DONE.
- IDLE:
  - start=1 at edge N latches a, b and borrow_in into shift_a, shift_b and br, clears the counter, and moves to BUSY.
  - busy is high from edge N.
- BUSY, on each edge:
  - d = shift_a[0] ^ shift_b[0] ^ br.
  - br_next = (~shift_a[0] & shift_b[0]) | (~(shift_a[0] ^ shift_b[0]) & br).
  - shift_a and shift_b shift right by 1.
  - d shifts into the MSB of the internal shift_d register.
  - The counter increments.
- Completion:
  - The edge where the counter equals NUM_BITS-1 processes the final bit. That is edge N+16 for the default width.
  - On that edge, diff takes the final shifted value, underflow takes br_next, and the state moves to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle, edges N+16 to N+17.
  - Next edge: start=1 accepts a new operation (back-to-back, moves to BUSY); otherwise the state moves to IDLE.
- Latency: 16 edges from the accepting edge to a valid result. Peak throughput is one operation per 17 cycles.
- start while BUSY is ignored: no restart and no relatch of the operands.
- diff and underflow change only on a completion edge or on reset. They hold their values through IDLE and through a subsequent BUSY phase.
- Input changes after acceptance have no effect on the operation in flight.
- Reset mid-operation: the operation is aborted with no done pulse; outputs return to 0.
- Arithmetic is unsigned modulo 2^NUM_BITS:
  - diff = (a - b - borrow_in) mod 2^NUM_BITS.
  - underflow is the bit NUM_BITS borrow.
- The design is fully synchronous except for the reset. There are no combinational paths from inputs to outputs.

Test Plan:
1. Reset, then a=0x0000, b=0x0000, borrow_in=0, start pulse -> busy for 16 cycles, done pulse on edge N+16, diff=0x0000, underflow=0.
2. a=0x0001, b=0x0002, borrow_in=0 -> diff=0xFFFF, underflow=1; both hold for 5 idle cycles after done.
3. a=0xF918, b=0x0001, borrow_in=1 -> diff=0xF916, underflow=0. Then a=0x0221, b=0xFCAC, borrow_in=0, start held high during DONE (back-to-back) -> diff=0x0575, underflow=1, 17 cycles after the first done.
4. Start a=0x2345, b=0x1111; at cycle 5, pulse start with a=0xFFFF, b=0x0000 -> the second start is ignored; result diff=0x1234, underflow=0; exactly one done pulse.
5. Start a=0xFDBA, b=0x0123; assert n_rst low asynchronously at cycle 8, mid-clock -> diff, underflow, busy and done all go 0 immediately; no done pulse after release; the next operation (a=0x0010, b=0x0010, borrow_in=1) gives diff=0xFFFF, underflow=1.
6. Randomized: 100 operand triples compared against the reference a - b - borrow_in -> every diff and underflow matches; done fires exactly once per accepted start.
